cpu_sys_pio_master: RTL and testbench

//  Avalon-MM initiator that drives a PIO-style slave: address[2:0], chipselect, write_n, writedata, readdata.

---
 rtl/cpu_sys_pio_master_if.sv | 30 +++
 rtl/cpu_sys_pio_master.sv | 197 +++++++++++++++++++
 tb/tb_cpu_sys_pio_master.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_sys_pio_master_if.sv
// cpu_sys_pio_master_if: command/response port plus Avalon-MM PIO bus of the PIO initiator.
interface cpu_sys_pio_master_if;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 3;

  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic [AW-1:0] address;
  logic          chipselect;
  logic          write_n;
  logic [DW-1:0] writedata;
  logic [DW-1:0] readdata;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready, readdata,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, address, chipselect, write_n, writedata
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready, readdata,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, address, chipselect, write_n, writedata
  );
endinterface

// File: rtl/cpu_sys_pio_master.sv
// cpu_sys_pio_master: Avalon-MM initiator driving a PIO slave with write, read and
// poll-until-set commands, one response per command.
// Optional define PIO_MASTER_TIMEOUT_EN: give up a poll after POLL_TIMEOUT non-matching reads.
module cpu_sys_pio_master #(
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned POLL_GAP     = 8,
  parameter int unsigned POLL_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  cpu_sys_pio_master_if.master  bus
);
  localparam int unsigned DW       = 32;
  localparam int unsigned AW       = 3;
  localparam int unsigned RCW      = 3;
  localparam int unsigned GCW      = 8;
  localparam int unsigned GAP_LAST = (POLL_GAP == 0) ? 0 : POLL_GAP - 1;

  localparam logic [1:0] OP_WR   = 2'b00;
  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_POLL = 2'b10;

  if (READ_LATENCY < 1 || READ_LATENCY > 4 || POLL_GAP > 255 || POLL_TIMEOUT < 1) begin : g_bad_params
    $error("cpu_sys_pio_master: parameter out of range");
  end

  typedef enum logic [2:0] {IDLE, WR, RD, GAP, CLR, RESP} state_e;

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   data_q, data_d;
  logic [DW-1:0]   sample_q, sample_d;
  logic [RCW-1:0]  rd_cnt_q, rd_cnt_d;
  logic [GCW-1:0]  gap_cnt_q, gap_cnt_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic            cmd_ready_q, rsp_valid_q;
  logic [AW-1:0]   address_q;
  logic            cs_q, write_n_q;
  logic [DW-1:0]   writedata_q;
  logic            cs_d, wr_d, timed_out;

`ifdef PIO_MASTER_TIMEOUT_EN
  localparam int unsigned PCW = $clog2(POLL_TIMEOUT + 1);
  logic [PCW-1:0]  poll_cnt_q, poll_cnt_d;

  // Completed non-matching poll reads of the current command
  always_ff @(posedge clk or posedge reset) begin
    if (reset) poll_cnt_q <= '0;
    else       poll_cnt_q <= poll_cnt_d;
  end
`endif

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.address    = address_q;
  assign bus.chipselect = cs_q;
  assign bus.write_n    = write_n_q;
  assign bus.writedata  = writedata_q;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state, command capture, read sampling and response selection
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    data_d     = data_q;
    sample_d   = sample_q;
    rd_cnt_d   = rd_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    timed_out  = 1'b0;
`ifdef PIO_MASTER_TIMEOUT_EN
    poll_cnt_d = poll_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          op_d     = bus.cmd_op;
          addr_d   = bus.cmd_addr;
          data_d   = bus.cmd_data;
          rd_cnt_d = '0;
`ifdef PIO_MASTER_TIMEOUT_EN
          poll_cnt_d = '0;
`endif
          case (bus.cmd_op)
            OP_WR:          state_d = WR;
            OP_RD, OP_POLL: state_d = RD;
            default: begin
              state_d    = RESP;
              rsp_err_d  = 1'b1;
              rsp_data_d = '0;
            end
          endcase
        end
      end
      WR: begin
        state_d    = RESP;
        rsp_data_d = data_q;
        rsp_err_d  = 1'b0;
      end
      RD: begin
        if (rd_cnt_q == RCW'(READ_LATENCY)) begin
          sample_d = bus.readdata;
          rd_cnt_d = '0;
          if (op_q != OP_POLL) begin
            state_d    = RESP;
            rsp_data_d = bus.readdata;
            rsp_err_d  = 1'b0;
          end else if (|(bus.readdata & data_q)) begin
            state_d = CLR;
          end else begin
`ifdef PIO_MASTER_TIMEOUT_EN
            timed_out  = (poll_cnt_q == PCW'(POLL_TIMEOUT - 1));
            poll_cnt_d = poll_cnt_q + PCW'(1);
`endif
            if (timed_out) begin
              state_d    = RESP;
              rsp_data_d = bus.readdata;
              rsp_err_d  = 1'b1;
            end else if (POLL_GAP == 0) begin
              state_d = RD;
            end else begin
              state_d   = GAP;
              gap_cnt_d = '0;
            end
          end
        end else begin
          rd_cnt_d = rd_cnt_q + RCW'(1);
        end
      end
      GAP: begin
        if (gap_cnt_q == GCW'(GAP_LAST)) begin
          state_d  = RD;
          rd_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + GCW'(1);
        end
      end
      CLR: begin
        state_d    = RESP;
        rsp_data_d = sample_q;
        rsp_err_d  = 1'b0;
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    cs_d = (state_d == WR) || (state_d == RD) || (state_d == CLR);
    wr_d = (state_d == WR) || (state_d == CLR);
  end

  // Datapath and registered bus outputs, aligned with the state they belong to
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q        <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      sample_q    <= '0;
      rd_cnt_q    <= '0;
      gap_cnt_q   <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      address_q   <= '0;
      cs_q        <= 1'b0;
      write_n_q   <= 1'b1;
      writedata_q <= '0;
    end else begin
      op_q        <= op_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      sample_q    <= sample_d;
      rd_cnt_q    <= rd_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      cmd_ready_q <= (state_d == IDLE);
      rsp_valid_q <= (state_d == RESP);
      address_q   <= addr_d;
      cs_q        <= cs_d;
      write_n_q   <= !wr_d;
      if (wr_d) writedata_q <= data_d;
    end
  end
endmodule

// File: tb/tb_cpu_sys_pio_master.sv
// tb_cpu_sys_pio_master: randomized scenarios against a PIO slave model and a register-level
// expectation model of write/read/poll results and bus activity.
module tb_cpu_sys_pio_master;
  localparam int unsigned RL    = 1;
  localparam int unsigned GAP   = 8;
  localparam int unsigned TO    = 4;
  localparam int          BOUND = 2000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cpu_sys_pio_master_if bus();

  cpu_sys_pio_master #(.READ_LATENCY(RL), .POLL_GAP(GAP), .POLL_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // PIO slave: 8 registers, offset 3 is write-to-clear, registered readdata of latency RL
  logic [31:0] sregs [8];
  logic [31:0] rpipe [RL];
  logic        ld_en;
  logic [2:0]  ld_addr;
  logic [31:0] ld_data;
  always @(posedge clk) begin
    if (ld_en) sregs[ld_addr] <= ld_data;
    else if (bus.chipselect === 1'b1 && bus.write_n === 1'b0)
      sregs[bus.address] <= (bus.address == 3'd3) ? (sregs[3] & ~bus.writedata) : bus.writedata;
    rpipe[0] <= sregs[bus.address];
    for (int i = 1; i < int'(RL); i++) rpipe[i] <= rpipe[i-1];
  end
  assign bus.readdata = rpipe[RL-1];

  // Bus monitor: collapses chipselect activity into runs (kind, address, data, length, idle before)
  typedef struct { bit wr; logic [2:0] addr; logic [31:0] data; int len; int gap; } run_t;
  run_t runs[$];
  run_t cur;
  bit   in_run = 1'b0;
  int   idle = 0;
  always @(negedge clk) begin
    if (bus.chipselect === 1'b1) begin
      if (in_run && cur.wr == !bus.write_n && cur.addr == bus.address) cur.len <= cur.len + 1;
      else begin
        if (in_run) runs.push_back(cur);
        cur <= '{wr: !bus.write_n, addr: bus.address, data: bus.writedata, len: 1, gap: idle};
        in_run <= 1'b1;
        idle <= 0;
      end
    end else begin
      if (in_run) runs.push_back(cur);
      in_run <= 1'b0;
      idle <= idle + 1;
    end
  end

  // Expected slave register contents
  logic [31:0] mregs [8];

  task automatic load_reg(input logic [2:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
    mregs[a] = d;
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [2:0] a, input logic [31:0] d, output int waited);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_addr = a; bus.cmd_data = d;
    waited = 0;
    while (bus.cmd_ready !== 1'b1 && waited < 100) begin @(negedge clk); waited++; end
    checks++;
    if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL cmd_accept: cmd_ready=%b required 1", bus.cmd_ready); end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    checks++;
    if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL cmd_ready_busy: cmd_ready=%b required 0", bus.cmd_ready); end
  endtask

  task automatic wait_rsp(input int hold, output logic [31:0] d, output logic e);
    int n = 0;
    while (bus.rsp_valid !== 1'b1 && n < BOUND) begin @(negedge clk); n++; end
    checks++;
    if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL rsp_timeout: rsp_valid=%b required 1", bus.rsp_valid); end
    d = bus.rsp_data; e = bus.rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== d || bus.rsp_err !== e || bus.cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL rsp_hold: valid=%b data=%h err=%b ready=%b required 1 %h %b 0",
                 bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.cmd_ready, d, e);
      end
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL rsp_release: rsp_valid=%b cmd_ready=%b required 0 1", bus.rsp_valid, bus.cmd_ready);
    end
  endtask

  task automatic run_write(input logic [2:0] a, input logic [31:0] d);
    int base, w; logic [31:0] rd; logic re;
    base = runs.size();
    do_cmd(2'b00, a, d, w);
    wait_rsp(int'($urandom_range(0, 3)), rd, re);
    mregs[a] = (a == 3'd3) ? (mregs[a] & ~d) : d;
    checks++;
    if (rd !== d || re !== 1'b0) begin errors++; $display("FAIL write_rsp: data=%h err=%b required %h 0", rd, re, d); end
    checks++;
    if (runs.size() != base + 1) begin errors++; $display("FAIL write_runs: runs=%0d required %0d", runs.size() - base, 1); end
    else if (runs[base].wr != 1'b1 || runs[base].addr !== a || runs[base].data !== d || runs[base].len != 1) begin
      errors++;
      $display("FAIL write_bus: wr=%b addr=%0d data=%h len=%0d required 1 %0d %h 1",
               runs[base].wr, runs[base].addr, runs[base].data, runs[base].len, a, d);
    end
  endtask

  task automatic run_read(input logic [2:0] a);
    int base, w; logic [31:0] rd; logic re;
    base = runs.size();
    do_cmd(2'b01, a, $urandom, w);
    wait_rsp(int'($urandom_range(0, 3)), rd, re);
    checks++;
    if (rd !== mregs[a] || re !== 1'b0) begin errors++; $display("FAIL read_rsp: data=%h err=%b required %h 0", rd, re, mregs[a]); end
    checks++;
    if (runs.size() != base + 1) begin errors++; $display("FAIL read_runs: runs=%0d required 1", runs.size() - base); end
    else if (runs[base].wr != 1'b0 || runs[base].addr !== a || runs[base].len != int'(RL + 1)) begin
      errors++;
      $display("FAIL read_bus: wr=%b addr=%0d len=%0d required 0 %0d %0d", runs[base].wr, runs[base].addr, runs[base].len, a, RL + 1);
    end
  endtask

  // Poll where the k-th read is the first to see a mask bit; v has no mask bits set
  task automatic run_poll(input logic [2:0] a, input logic [31:0] m, input int k, input logic [31:0] v);
    int base, w, n; logic [31:0] rd, fin; logic re;
    fin = v | (m & (~m + 32'd1));
    if (k == 1) load_reg(a, fin); else load_reg(a, v);
    base = runs.size();
    do_cmd(2'b10, a, m, w);
    if (k > 1) begin
      n = 0;
      while (runs.size() < base + k - 1 && n < BOUND) begin @(negedge clk); n++; end
      load_reg(a, fin);
    end
    wait_rsp(int'($urandom_range(0, 2)), rd, re);
    checks++;
    if (rd !== fin || re !== 1'b0) begin errors++; $display("FAIL poll_rsp: data=%h err=%b required %h 0", rd, re, fin); end
    checks++;
    if (runs.size() != base + k + 1) begin errors++; $display("FAIL poll_runs: runs=%0d required %0d", runs.size() - base, k + 1); end
    else begin
      for (int i = 0; i < k; i++) begin
        checks++;
        if (runs[base+i].wr != 1'b0 || runs[base+i].addr !== a || runs[base+i].len != int'(RL + 1) ||
            (i > 0 && runs[base+i].gap != int'(GAP))) begin
          errors++;
          $display("FAIL poll_read%0d: wr=%b addr=%0d len=%0d gap=%0d required 0 %0d %0d %0d",
                   i, runs[base+i].wr, runs[base+i].addr, runs[base+i].len, runs[base+i].gap, a, RL + 1, GAP);
        end
      end
      checks++;
      if (runs[base+k].wr != 1'b1 || runs[base+k].addr !== a || runs[base+k].data !== m ||
          runs[base+k].len != 1 || runs[base+k].gap != 0) begin
        errors++;
        $display("FAIL poll_clear: wr=%b addr=%0d data=%h len=%0d gap=%0d required 1 %0d %h 1 0",
                 runs[base+k].wr, runs[base+k].addr, runs[base+k].data, runs[base+k].len, runs[base+k].gap, a, m);
      end
    end
    mregs[a] = (a == 3'd3) ? (fin & ~m) : m;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_addr = '0; bus.cmd_data = '0; bus.rsp_ready = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    #1 reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) load_reg(3'(i), $urandom);
    checks++;
    if (bus.cmd_ready !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.rsp_data !== 32'h0 || bus.rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp: ready=%b valid=%b data=%h err=%b required 0 0 0 0", bus.cmd_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_err);
    end
    checks++;
    if (bus.address !== 3'h0 || bus.chipselect !== 1'b0 || bus.write_n !== 1'b1 || bus.writedata !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus: addr=%h cs=%b write_n=%b wdata=%h required 0 0 1 0", bus.address, bus.chipselect, bus.write_n, bus.writedata);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release: cmd_ready=%b rsp_valid=%b required 1 0", bus.cmd_ready, bus.rsp_valid);
    end
  endtask

  task automatic test_write;
    run_write(3'd0, 32'hA5A5_0001);
    for (int i = 0; i < 4; i++) run_write(3'($urandom_range(0, 7)), $urandom);
  endtask

  task automatic test_read;
    load_reg(3'd0, 32'h1234_5678);
    run_read(3'd0);
    for (int i = 0; i < 5; i++) run_read(3'($urandom_range(0, 7)));
  endtask

  task automatic test_poll;
    logic [31:0] m;
    run_poll(3'd3, 32'h0000_0002, 3, 32'h0);
    run_read(3'd3);
    for (int i = 0; i < 4; i++) begin
      m = $urandom & $urandom;
      if (m == 32'h0) m = 32'h8000_0000;
      run_poll(3'($urandom_range(0, 7)), m, int'($urandom_range(1, 3)), $urandom & ~m);
    end
    run_read(3'd3);
  endtask

`ifdef PIO_MASTER_TIMEOUT_EN
  task automatic test_timeout;
    int base, w; logic [31:0] rd, m, v; logic re; logic [2:0] a;
    for (int t = 0; t < 2; t++) begin
      m = (t == 0) ? 32'h0 : ($urandom | 32'h1);
      v = $urandom & ~m;
      a = 3'($urandom_range(0, 7));
      load_reg(a, v);
      base = runs.size();
      do_cmd(2'b10, a, m, w);
      wait_rsp(1, rd, re);
      checks++;
      if (rd !== v || re !== 1'b1) begin errors++; $display("FAIL timeout_rsp: data=%h err=%b required %h 1", rd, re, v); end
      checks++;
      if (runs.size() != base + int'(TO)) begin errors++; $display("FAIL timeout_reads: runs=%0d required %0d", runs.size() - base, TO); end
      else begin
        for (int i = 0; i < int'(TO); i++) begin
          checks++;
          if (runs[base+i].wr != 1'b0 || runs[base+i].addr !== a) begin
            errors++; $display("FAIL timeout_run%0d: wr=%b addr=%0d required 0 %0d", i, runs[base+i].wr, runs[base+i].addr, a);
          end
        end
      end
    end
  endtask
`endif

  task automatic test_illegal_backpressure;
    int w; bit bad = 1'b0;
    bus.rsp_ready = 1'b0;
    do_cmd(2'b11, 3'($urandom_range(0, 7)), $urandom, w);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_data !== 32'h0 ||
          bus.cmd_ready !== 1'b0 || bus.chipselect !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL illegal_hold: valid=%b err=%b data=%h ready=%b cs=%b required 1 1 0 0 0",
               bus.rsp_valid, bus.rsp_err, bus.rsp_data, bus.cmd_ready, bus.chipselect);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL illegal_release: rsp_valid=%b cmd_ready=%b required 0 1", bus.rsp_valid, bus.cmd_ready);
    end
  endtask

  task automatic test_back_to_back;
    int w, n; logic [2:0] a; logic [31:0] d;
    a = 3'($urandom_range(0, 2));
    d = $urandom;
    bus.rsp_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      do_cmd((t == 0) ? 2'b00 : 2'b01, a, d, w);
      if (t == 1) begin
        checks++;
        if (w != 0) begin errors++; $display("FAIL b2b_accept: waited=%0d required 0", w); end
      end
      n = 0;
      while (bus.rsp_valid !== 1'b1 && n < BOUND) begin @(negedge clk); n++; end
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== d || bus.rsp_err !== 1'b0) begin
        errors++; $display("FAIL b2b_rsp%0d: valid=%b data=%h err=%b required 1 %h 0", t, bus.rsp_valid, bus.rsp_data, bus.rsp_err, d);
      end
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_one_resp%0d: rsp_valid=%b cmd_ready=%b required 0 1", t, bus.rsp_valid, bus.cmd_ready);
      end
    end
    bus.rsp_ready = 1'b0;
    mregs[a] = d;
  endtask

  task automatic test_reset_mid_poll;
    int base, w, n; bit bad = 1'b0;
    load_reg(3'd5, 32'h0);
    base = runs.size();
    do_cmd(2'b10, 3'd5, 32'h1, w);
    n = 0;
    while (runs.size() < base + 1 && n < BOUND) begin @(negedge clk); n++; end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (bus.chipselect !== 1'b0 || bus.write_n !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_gap: cs=%b write_n=%b valid=%b ready=%b required 0 1 0 0", bus.chipselect, bus.write_n, bus.rsp_valid, bus.cmd_ready);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    do_cmd(2'b10, 3'd5, 32'h1, w);
    checks++;
    if (bus.chipselect !== 1'b1) begin errors++; $display("FAIL poll_reading: cs=%b required 1", bus.chipselect); end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.chipselect !== 1'b0 || bus.write_n !== 1'b1) begin
      errors++; $display("FAIL reset_async: cs=%b write_n=%b required 0 1", bus.chipselect, bus.write_n);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0 || bus.chipselect !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL reset_no_rsp: activity after reset required none"); end
    run_read(3'd5);
    run_write(3'd5, $urandom);
    run_read(3'd5);
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_poll;
`ifdef PIO_MASTER_TIMEOUT_EN
    test_timeout;
`endif
    test_illegal_backpressure;
    test_back_to_back;
    test_reset_mid_poll;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end
endmodule
